// File: rtl/microsequencer.sv
// Microinstruction sequencer: T-state counter, hard-wired fetch steps, ROM pass-through,
// run/halt/single-step/wait pacing. Optional instruction counter via MICROSEQUENCER_ICOUNT_EN.
module microsequencer #(
  parameter int unsigned TBITS     = 3,
  parameter bit          START_RUN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_bar,
  input  logic [7:0]           opcode,
  input  logic [15:0]          urom_data,
  input  logic                 run,
  input  logic                 step,
  input  logic                 wait_req,
  output logic [8+TBITS-1:0]   urom_addr,
  output logic [15:0]          uinstr,
  output logic [TBITS-1:0]     tstate,
  output logic                 halted,
`ifdef MICROSEQUENCER_ICOUNT_EN
  output logic [15:0]          icount,
`endif
  output logic                 instr_done
);

  localparam logic [15:0] UI_NOP    = 16'h8000;
  localparam logic [15:0] UI_FETCH0 = 16'h8020;
  localparam logic [15:0] UI_FETCH1 = 16'hB440;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t         RESET_STATE = START_RUN ? ST_RUN : ST_HALT;
  localparam logic [TBITS-1:0] T_LAST    = '1;

  state_t           state_q, state_d;
  logic [TBITS-1:0] tstate_q, tstate_d;
  logic             pend_q, pend_d;
  logic             end_of_instr;
  logic             rt;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q  <= RESET_STATE;
      tstate_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tstate_q <= tstate_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    rt           = urom_data[15] & urom_data[11];
    end_of_instr = 1'b0;
    uinstr       = urom_data;
    state_d      = state_q;
    tstate_d     = tstate_q;
    pend_d       = pend_q;
    if (state_q == ST_HALT) begin
      uinstr   = UI_NOP;
      tstate_d = '0;
      if (run) begin
        state_d = ST_RUN;
        pend_d  = 1'b0;
      end else if (step) begin
        state_d = ST_RUN;
        pend_d  = 1'b1;
      end
    end else if (wait_req) begin
      uinstr = UI_NOP;
    end else begin
      if (tstate_q == TBITS'(0)) begin
        uinstr = UI_FETCH0;
      end else if (tstate_q == TBITS'(1)) begin
        uinstr = UI_FETCH1;
      end
      // RT is only meaningful once the ROM word is actually being issued (T>=2)
      end_of_instr = ((tstate_q >= TBITS'(2)) && rt) || (tstate_q == T_LAST);
      if (end_of_instr) begin
        tstate_d = '0;
        pend_d   = 1'b0;
        if (!run || pend_q) begin
          state_d = ST_HALT;
        end
      end else begin
        tstate_d = tstate_q + TBITS'(1);
      end
    end
  end

  assign urom_addr  = {opcode, tstate_q - TBITS'(2)};
  assign tstate     = tstate_q;
  assign halted     = (state_q == ST_HALT);
  assign instr_done = end_of_instr;

`ifdef MICROSEQUENCER_ICOUNT_EN
  logic [15:0] icount_q;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      icount_q <= '0;
    end else if (end_of_instr) begin
      icount_q <= icount_q + 16'd1;
    end
  end

  assign icount = icount_q;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: random and directed pacing against a behavioural model.
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        reset_bar;
  logic [7:0]  opcode;
  logic [15:0] urom_data;
  logic        run, step, wait_req;
  logic [10:0] urom_addr;
  logic [15:0] uinstr;
  logic [2:0]  tstate;
  logic        halted, instr_done;
  logic [10:0] h_urom_addr;
  logic [15:0] h_uinstr;
  logic [2:0]  h_tstate;
  logic        h_halted, h_instr_done;
`ifdef MICROSEQUENCER_ICOUNT_EN
  logic [15:0] icount, h_icount;
`endif

  logic [15:0] rom [0:2047];

  microsequencer #(.TBITS(3), .START_RUN(1'b1)) dut (
    .clk(clk), .reset_bar(reset_bar), .opcode(opcode), .urom_data(urom_data),
    .run(run), .step(step), .wait_req(wait_req), .urom_addr(urom_addr),
    .uinstr(uinstr), .tstate(tstate), .halted(halted),
`ifdef MICROSEQUENCER_ICOUNT_EN
    .icount(icount),
`endif
    .instr_done(instr_done)
  );

  // Second instance only observed while reset is held, to cover START_RUN=0.
  microsequencer #(.TBITS(3), .START_RUN(1'b0)) dut_h (
    .clk(clk), .reset_bar(reset_bar), .opcode(opcode), .urom_data(urom_data),
    .run(run), .step(step), .wait_req(wait_req), .urom_addr(h_urom_addr),
    .uinstr(h_uinstr), .tstate(h_tstate), .halted(h_halted),
`ifdef MICROSEQUENCER_ICOUNT_EN
    .icount(h_icount),
`endif
    .instr_done(h_instr_done)
  );

  always #5 clk = ~clk;

  always_comb urom_data = rom[urom_addr];

  typedef struct {
    logic [15:0] ui;
    logic [2:0]  t;
    logic        hl;
    logic        dn;
    logic [10:0] ad;
    logic        adv;
    logic        hchk;
    logic [15:0] ic;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: running/halted, current step number, pending single step, instr count
  bit m_on;
  int m_t;
  bit m_pend;
  int m_ic;

  function automatic exp_t mk_exp(input logic w, input logic [7:0] op, input logic hc);
    exp_t        e;
    logic [15:0] word;
    logic [10:0] a;
    a      = {op, 3'(m_t - 2)};
    word   = rom[a];
    e.t    = 3'(m_t);
    e.hl   = !m_on;
    e.ad   = a;
    e.adv  = m_on && (m_t >= 2);
    e.hchk = hc;
    e.ic   = 16'(m_ic);
    if (!m_on || w)   e.ui = 16'h8000;
    else if (m_t == 0) e.ui = 16'h8020;
    else if (m_t == 1) e.ui = 16'hB440;
    else               e.ui = word;
    e.dn = m_on && !w && ((m_t >= 2 && word[15] && word[11]) || m_t == 7);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: DUT presents one microinstruction per cycle; sample mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("uinstr", 32'(uinstr), 32'(e.ui));
        chk("tstate", 32'(tstate), 32'(e.t));
        chk("halted", 32'(halted), 32'(e.hl));
        chk("instr_done", 32'(instr_done), 32'(e.dn));
        if (e.adv) chk("urom_addr", 32'(urom_addr), 32'(e.ad));
`ifdef MICROSEQUENCER_ICOUNT_EN
        chk("icount", 32'(icount), 32'(e.ic));
`endif
        if (e.hchk) begin
          chk("haltrst_uinstr", 32'(h_uinstr), 32'h8000);
          chk("haltrst_tstate", 32'(h_tstate), 32'd0);
          chk("haltrst_halted", 32'(h_halted), 32'd1);
          chk("haltrst_done", 32'(h_instr_done), 32'd0);
        end
      end
    end
  end

  // One clock of stimulus: drive, predict, push, then advance the model across the edge
  task automatic cyc(input logic r, input logic s, input logic w, input logic [7:0] op);
    exp_t e;
    run = r; step = s; wait_req = w; opcode = op;
    e = mk_exp(w, op, 1'b0);
    sb.push_back(e);
    if (e.dn) m_ic = (m_ic + 1) % 65536;
    if (m_on) begin
      if (!w) begin
        if (e.dn) begin
          m_t = 0;
          if (!r || m_pend) m_on = 0;
          m_pend = 0;
        end else begin
          m_t = m_t + 1;
        end
      end
    end else begin
      m_t = 0;
      if (r) begin
        m_on = 1; m_pend = 0;
      end else if (s) begin
        m_on = 1; m_pend = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  // Asynchronous reset asserted mid-cycle; checked before any clock edge occurs
  task automatic do_reset();
    reset_bar = 1'b0;
    m_on = 1; m_t = 0; m_pend = 0; m_ic = 0;
    sb.push_back(mk_exp(wait_req, opcode, 1'b1));
    @(posedge clk); #1;
    reset_bar = 1'b1;
  endtask

  initial begin
    logic [7:0] op;
    for (int i = 0; i < 2048; i++) begin
      rom[i] = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rom[i][11] = 1'b0;
    end
    rom[11'h090] = 16'h8A00;
    for (int i = 0; i < 8; i++) rom[11'h1A0 + i] = rom[11'h1A0 + i] & 16'hF7FF;
    for (int i = 0; i < 8; i++) rom[11'h2B0 + i] = rom[11'h2B0 + i] & 16'hF7FF;
    rom[11'h2B2] = 16'h9800;

    reset_bar = 1'b0; run = 1'b1; step = 1'b0; wait_req = 1'b0; opcode = 8'h12;
    @(posedge clk); #1;
    do_reset();

    repeat (4) cyc(1'b1, 1'b0, 1'b0, 8'h12);
    repeat (18) cyc(1'b1, 1'b0, 1'b0, 8'h34);

    for (int i = 0; i < 16 && m_t != 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'h34);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 8'h34);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 8'h34);

    for (int i = 0; i < 16 && m_t != 2; i++) cyc(1'b1, 1'b0, 1'b0, 8'h56);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 8'h56);

    cyc(1'b0, 1'b1, 1'b0, 8'h56);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h56);
    cyc(1'b0, 1'b1, 1'b0, 8'h56);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 8'h56);

    for (int i = 0; i < 16 && !(m_on && m_t == 4); i++) cyc(1'b1, 1'b0, 1'b0, 8'h56);
    do_reset();
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 8'h12);

    repeat (800) begin
      case ($urandom_range(0, 3))
        0: op = 8'h12;
        1: op = 8'h34;
        2: op = 8'h56;
        default: op = 8'($urandom);
      endcase
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) < 2, op);
    end

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
